// File: rtl/bcp_axil_pkg.sv
// bcp_axil_pkg
// Shared types and helpers for the BCP AXI4-Lite control register slave.
//   RESP_OKAY / RESP_SLVERR : AXI response codes
//   word_t                  : one 32-bit control register
//   wr_state_t / rd_state_t : write and read channel states
//   byte_merge()            : applies a 4-bit byte-lane strobe to a register word
package bcp_axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef logic [31:0] word_t;

   // WR_HAVE_AW / WR_HAVE_W mean one half of the write has been latched
   // and the slave is waiting for the other half.
   typedef enum logic [1:0] {
      WR_IDLE    = 2'd0,
      WR_HAVE_AW = 2'd1,
      WR_HAVE_W  = 2'd2,
      WR_RESP    = 2'd3
   } wr_state_t;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_RESP = 1'b1
   } rd_state_t;

   function automatic word_t byte_merge(input word_t old_w, input word_t new_w,
                                        input logic [3:0] strb);
      word_t res;
      res = old_w;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/bcp_axil_regs_slave_if.sv
// bcp_axil_regs_slave_if
// AXI4-Lite bus bundle (AW, W, B, AR, R channels) for the BCP control port.
//   master modport : drives addresses, data, valids and response readies
//   slave  modport : drives channel readies and the B/R responses
// Parameters: ADDR_W (byte address width), DATA_W (data width, 32 only).
interface bcp_axil_regs_slave_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   S_AXI_AWADDR;
   logic [2:0]          S_AXI_AWPROT;
   logic                S_AXI_AWVALID;
   logic                S_AXI_AWREADY;
   logic [DATA_W-1:0]   S_AXI_WDATA;
   logic [DATA_W/8-1:0] S_AXI_WSTRB;
   logic                S_AXI_WVALID;
   logic                S_AXI_WREADY;
   logic [1:0]          S_AXI_BRESP;
   logic                S_AXI_BVALID;
   logic                S_AXI_BREADY;
   logic [ADDR_W-1:0]   S_AXI_ARADDR;
   logic [2:0]          S_AXI_ARPROT;
   logic                S_AXI_ARVALID;
   logic                S_AXI_ARREADY;
   logic [DATA_W-1:0]   S_AXI_RDATA;
   logic [1:0]          S_AXI_RRESP;
   logic                S_AXI_RVALID;
   logic                S_AXI_RREADY;

   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      input  S_AXI_AWREADY,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_WREADY,
      input  S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      input  S_AXI_ARREADY,
      input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      output S_AXI_RREADY
   );

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      output S_AXI_AWREADY,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_WREADY,
      output S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      output S_AXI_ARREADY,
      output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      input  S_AXI_RREADY
   );
endinterface

// File: rtl/bcp_axil_reg_bank.sv
// bcp_axil_reg_bank
// Register array behind the AXI4-Lite slave.
//   clk, rst            : clock, asynchronous active-high reset
//   wr_en/wr_idx        : commit a byte-strobed write to register wr_idx
//   wr_data/wr_strb     : write word and byte-lane enables
//   rd_idx -> rd_data   : combinational read mux (0 for indices past NUM_REGS)
//   reg_q               : all registers, reg i at [32i+31:32i]
//   reg_wr_stb          : one-cycle pulse per register written on the previous edge
module bcp_axil_reg_bank
   import bcp_axil_pkg::*;
#(
   parameter int NUM_REGS = 4,
   parameter int IDX_W    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [IDX_W-1:0]      wr_idx,
   input  word_t                 wr_data,
   input  logic [3:0]            wr_strb,
   input  logic [IDX_W-1:0]      rd_idx,
   output word_t                 rd_data,
   output logic [NUM_REGS*32-1:0] reg_q,
   output logic [NUM_REGS-1:0]   reg_wr_stb
);

   word_t regs [NUM_REGS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         reg_wr_stb <= '0;
      end else begin
         reg_wr_stb <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            // The strobe pulses even when wr_strb is all-zero: the core
            // sees every completed write, not only those that changed bits.
            if (wr_en && (int'(wr_idx) == i)) begin
               regs[i]       <= byte_merge(regs[i], wr_data, wr_strb);
               reg_wr_stb[i] <= 1'b1;
            end
         end
      end
   end

   // Reads the pre-edge contents, so a read and write to the same register
   // on one edge return the old value.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (int'(rd_idx) == i) rd_data = regs[i];
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
      assign reg_q[32*g +: 32] = regs[g];
   end

endmodule

// File: rtl/bcp_axil_regs_slave.sv
// bcp_axil_regs_slave
// AXI4-Lite slave terminating the BCP S00_AXI control port; write and read
// channels run independently with one outstanding transaction each.
//   ACLK, ARESET : clock, asynchronous active-high reset
//   s            : AXI4-Lite bus (slave modport)
//   reg_q        : register contents to the accelerator core
//   reg_wr_stb   : per-register one-cycle write pulse
// Build option BCP_AXIL_SLVERR_EN: out-of-range register indices return
// SLVERR, writes there are dropped and reads return 0. Without it the index
// aliases modulo NUM_REGS and every response is OKAY.
module bcp_axil_regs_slave
   import bcp_axil_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int NUM_REGS           = 4
) (
   input  logic                   ACLK,
   input  logic                   ARESET,
   bcp_axil_regs_slave_if.slave   s,
   output logic [NUM_REGS*32-1:0] reg_q,
   output logic [NUM_REGS-1:0]    reg_wr_stb
);

   localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

   if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_dw
      $error("bcp_axil_regs_slave supports only a 32-bit data bus");
   end
   if (NUM_REGS > (2 ** IDX_W)) begin : g_bad_nr
      $error("bcp_axil_regs_slave: NUM_REGS exceeds the address space");
   end

   wr_state_t        wr_state, wr_state_nx;
   rd_state_t        rd_state, rd_state_nx;
   logic             aw_hs, w_hs, ar_hs, wr_commit;
   logic [IDX_W-1:0] aw_idx_q;
   word_t            w_data_q;
   logic [3:0]       w_strb_q;
   logic [IDX_W-1:0] wr_idx_raw, rd_idx_raw, wr_idx, rd_idx;
   logic             wr_hit, rd_hit;
   word_t            wr_data, bank_rd_data;
   logic [3:0]       wr_strb;
   logic [1:0]       bresp_q, rresp_q;
   word_t            rdata_q;
   logic             unused_bits;

   assign unused_bits = ^{s.S_AXI_AWPROT, s.S_AXI_ARPROT,
                          s.S_AXI_AWADDR[1:0], s.S_AXI_ARADDR[1:0]};

   // Readies are gated by ARESET directly so they read 0 throughout reset.
   assign s.S_AXI_AWREADY = !ARESET && ((wr_state == WR_IDLE) || (wr_state == WR_HAVE_W));
   assign s.S_AXI_WREADY  = !ARESET && ((wr_state == WR_IDLE) || (wr_state == WR_HAVE_AW));
   assign s.S_AXI_BVALID  = (wr_state == WR_RESP);
   assign s.S_AXI_BRESP   = bresp_q;
   assign s.S_AXI_ARREADY = !ARESET && (rd_state == RD_IDLE);
   assign s.S_AXI_RVALID  = (rd_state == RD_RESP);
   assign s.S_AXI_RDATA   = rdata_q;
   assign s.S_AXI_RRESP   = rresp_q;

   assign aw_hs = s.S_AXI_AWVALID && s.S_AXI_AWREADY;
   assign w_hs  = s.S_AXI_WVALID  && s.S_AXI_WREADY;
   assign ar_hs = s.S_AXI_ARVALID && s.S_AXI_ARREADY;

   // Commit uses whichever half was latched earlier and the live bus for the other.
   assign wr_idx_raw = (wr_state == WR_HAVE_AW) ? aw_idx_q
                                                : s.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
   assign wr_data    = (wr_state == WR_HAVE_W) ? w_data_q : s.S_AXI_WDATA;
   assign wr_strb    = (wr_state == WR_HAVE_W) ? w_strb_q : s.S_AXI_WSTRB;
   assign rd_idx_raw = s.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

`ifdef BCP_AXIL_SLVERR_EN
   assign wr_hit = (int'(wr_idx_raw) < NUM_REGS);
   assign rd_hit = (int'(rd_idx_raw) < NUM_REGS);
   assign wr_idx = wr_idx_raw;
   assign rd_idx = rd_idx_raw;
`else
   assign wr_hit = 1'b1;
   assign rd_hit = 1'b1;
   assign wr_idx = IDX_W'(int'(wr_idx_raw) % NUM_REGS);
   assign rd_idx = IDX_W'(int'(rd_idx_raw) % NUM_REGS);
`endif

   // Write channel state
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) wr_state <= WR_IDLE;
      else        wr_state <= wr_state_nx;
   end

   always_comb begin
      wr_state_nx = wr_state;
      wr_commit   = 1'b0;
      case (wr_state)
         WR_IDLE: begin
            if (aw_hs && w_hs) begin
               wr_commit   = 1'b1;
               wr_state_nx = WR_RESP;
            end else if (aw_hs) begin
               wr_state_nx = WR_HAVE_AW;
            end else if (w_hs) begin
               wr_state_nx = WR_HAVE_W;
            end
         end
         WR_HAVE_AW: begin
            if (w_hs) begin
               wr_commit   = 1'b1;
               wr_state_nx = WR_RESP;
            end
         end
         WR_HAVE_W: begin
            if (aw_hs) begin
               wr_commit   = 1'b1;
               wr_state_nx = WR_RESP;
            end
         end
         WR_RESP: begin
            if (s.S_AXI_BREADY) wr_state_nx = WR_IDLE;
         end
         default: wr_state_nx = WR_IDLE;
      endcase
   end

   // Latched halves; only meaningful while the state says they are held.
   always_ff @(posedge ACLK) begin
      if (aw_hs) aw_idx_q <= s.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      if (w_hs) begin
         w_data_q <= s.S_AXI_WDATA;
         w_strb_q <= s.S_AXI_WSTRB;
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET)         bresp_q <= RESP_OKAY;
      else if (wr_commit) bresp_q <= wr_hit ? RESP_OKAY : RESP_SLVERR;
   end

   // Read channel state
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) rd_state <= RD_IDLE;
      else        rd_state <= rd_state_nx;
   end

   always_comb begin
      rd_state_nx = rd_state;
      case (rd_state)
         RD_IDLE: if (ar_hs) rd_state_nx = RD_RESP;
         RD_RESP: if (s.S_AXI_RREADY) rd_state_nx = RD_IDLE;
         default: rd_state_nx = RD_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
      end else if (ar_hs) begin
         rdata_q <= rd_hit ? bank_rd_data : '0;
         rresp_q <= rd_hit ? RESP_OKAY : RESP_SLVERR;
      end
   end

   bcp_axil_reg_bank #(
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W)
   ) u_bank (
      .clk        (ACLK),
      .rst        (ARESET),
      .wr_en      (wr_commit && wr_hit),
      .wr_idx     (wr_idx),
      .wr_data    (wr_data),
      .wr_strb    (wr_strb),
      .rd_idx     (rd_idx),
      .rd_data    (bank_rd_data),
      .reg_q      (reg_q),
      .reg_wr_stb (reg_wr_stb)
   );

endmodule
